// File: rtl/serial_tx_scheduler_pkg.sv
// Shared definitions for the serial transmit scheduler: FSM states, widths and
// the round-robin pointer wrap helper.
package serial_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } sched_state_t;

    localparam int DATA_W_DEFAULT = 8;
    localparam int ERR_ID_W       = 3;

    // Index following idx in a ring of num_req requesters.
    function automatic logic [ERR_ID_W-1:0] wrap_next(input logic [ERR_ID_W-1:0] idx,
                                                      input int num_req);
        if (int'(idx) >= num_req - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after rr_ptr,
// searching circularly. The pointer itself lives in the scheduler.
module rr_arbiter
    import serial_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ERR_ID_W-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]  winner_onehot,
    output logic [ERR_ID_W-1:0] winner_idx,
    output logic                any_req
);

    logic [ERR_ID_W-1:0] idx;
    logic [NUM_REQ-1:0]  shifted;

    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        any_req       = 1'b0;
        idx           = '0;
        shifted       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx     = ERR_ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            shifted = req >> idx;
            if (!any_req && shifted[0]) begin
                any_req       = 1'b1;
                winner_idx    = idx;
                winner_onehot = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin sharing of one serial transmitter between NUM_REQ byte producers.
// Optional start timeout enabled by defining SERIAL_TX_TIMEOUT_EN.
module serial_tx_scheduler
    import serial_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      tx_send,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      err,
    output logic [ERR_ID_W-1:0]       err_id
);

    sched_state_t        state;
    logic [ERR_ID_W-1:0] rr_ptr;
    logic [ERR_ID_W-1:0] winner;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [ERR_ID_W-1:0] win_idx;
    logic                any_req;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arbiter (
        .req          (req),
        .rr_ptr       (rr_ptr),
        .winner_onehot(win_onehot),
        .winner_idx   (win_idx),
        .any_req      (any_req)
    );

`ifdef SERIAL_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    start_cnt;
    logic                err_r;
    logic [ERR_ID_W-1:0] err_id_r;

    assign err    = err_r;
    assign err_id = err_id_r;
`else
    assign err    = 1'b0;
    assign err_id = '0;
`endif

    // A stale transfer (tx_busy already high) blocks arbitration until it ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            winner    <= '0;
            done      <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            tx_send   <= 1'b0;
            tx_data   <= '0;
`ifdef SERIAL_TX_TIMEOUT_EN
            start_cnt <= '0;
            err_r     <= 1'b0;
            err_id_r  <= '0;
`endif
        end else begin
            done <= '0;
`ifdef SERIAL_TX_TIMEOUT_EN
            err_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req && !tx_busy) begin
                        winner    <= win_idx;
                        grant     <= win_onehot;
                        tx_data   <= DATA_W'(req_data >> (int'(win_idx) * DATA_W));
                        tx_send   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
`ifdef SERIAL_TX_TIMEOUT_EN
                        start_cnt <= '0;
`endif
                    end
                end
                START: begin
                    if (tx_busy) begin
                        tx_send <= 1'b0;
                        state   <= SHIFT;
                    end
`ifdef SERIAL_TX_TIMEOUT_EN
                    else if (start_cnt == CNT_W'(TIMEOUT - 1)) begin
                        tx_send  <= 1'b0;
                        err_r    <= 1'b1;
                        err_id_r <= winner;
                        rr_ptr   <= wrap_next(winner, NUM_REQ);
                        grant    <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
`endif
                end
                SHIFT: begin
                    if (!tx_busy) begin
                        done   <= NUM_REQ'(1) << winner;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= wrap_next(winner, NUM_REQ);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
